// File: rtl/custom_instr_pkg.sv
// Opcodes and operation types shared by the bit-count coprocessor.
package custom_instr_pkg;

  localparam logic [6:0] OPCODE_CNTB  = 7'h2B;
  localparam logic [6:0] OPCODE_LDCNT = 7'h5B;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_CNTB  = 2'd1,
    OP_LDCNT = 2'd2
  } op_e;

  function automatic op_e decode_op(input logic [6:0] opcode);
    case (opcode)
      OPCODE_CNTB:  return OP_CNTB;
      OPCODE_LDCNT: return OP_LDCNT;
      default:      return OP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/bit_popcount.sv
// Combinational population count of an XLEN-bit word.
module bit_popcount #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]        data_i,
  output logic [$clog2(XLEN):0]  count_o
);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < XLEN; i++) begin
      count_o = count_o + {{$clog2(XLEN){1'b0}}, data_i[i]};
    end
  end

endmodule

// File: rtl/xif_bitcoproc.sv
// XIF coprocessor: in-order queue of popcount instructions (register and
// memory operand), executed one at a time once committed.
module xif_bitcoproc
  import custom_instr_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ID_WIDTH = 4,
  parameter int DEPTH    = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                issue_valid_i,
  output logic                issue_ready_o,
  input  logic [31:0]         issue_instr_i,
  input  logic [ID_WIDTH-1:0] issue_id_i,
  input  logic [XLEN-1:0]     issue_rs0_i,
  input  logic [XLEN-1:0]     issue_rs1_i,
  output logic                issue_accept_o,
  output logic                issue_writeback_o,
  output logic                issue_loadstore_o,
  input  logic                commit_valid_i,
  input  logic [ID_WIDTH-1:0] commit_id_i,
  input  logic                commit_kill_i,
  output logic                mem_valid_o,
  input  logic                mem_ready_i,
  output logic [ID_WIDTH-1:0] mem_id_o,
  output logic [31:0]         mem_addr_o,
  output logic                mem_we_o,
  output logic [XLEN/8-1:0]   mem_be_o,
  output logic [1:0]          mem_mode_o,
  output logic                mem_spec_o,
  input  logic                mem_result_valid_i,
  input  logic [XLEN-1:0]     mem_rdata_i,
  output logic                result_valid_o,
  input  logic                result_ready_i,
  output logic [ID_WIDTH-1:0] result_id_o,
  output logic [4:0]          result_rd_o,
  output logic [XLEN-1:0]     result_data_o,
  output logic                result_we_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int NW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_MEMREQ, S_MEMWAIT, S_EXEC, S_RESULT
  } state_e;

  typedef struct packed {
    logic [ID_WIDTH-1:0] id;
    logic [4:0]          rd;
    op_e                 op;
    logic [XLEN-1:0]     rs0;
    logic [XLEN-1:0]     rs1;
    logic                committed;
    logic                killed;
  } entry_t;

  entry_t          q_q [DEPTH];
  entry_t          q_d [DEPTH];
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  state_e          state_q, state_d;
  logic [XLEN-1:0] rdata_q, rdata_d, data_q, data_d;

  entry_t          head;
  logic [DEPTH-1:0] ent_valid;
  op_e             issue_op;
  logic            known, enq, deq, head_hit, head_go, head_kill;
  logic [XLEN-1:0] pop_in;
  logic [NW-1:0]   pop_cnt;
  logic            unused_ok;

  assign head     = q_q[head_q];
  assign issue_op = decode_op(issue_instr_i[6:0]);
  assign known    = (issue_op != OP_NONE);

  assign issue_ready_o     = (count_q != FULL);
  assign issue_accept_o    = rst_ni & known;
  assign issue_writeback_o = rst_ni & known;
  assign issue_loadstore_o = rst_ni & (issue_op == OP_LDCNT);
  assign enq               = issue_valid_i & issue_ready_o & known;

  // Slot gi is live when its distance from the head is below the occupancy.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_valid
      assign ent_valid[gi] = ({1'b0, PW'(gi) - head_q} < count_q);
    end
  endgenerate

  // A commit for the head in the current cycle is honoured immediately.
  assign head_hit  = (count_q != '0) && commit_valid_i && (commit_id_i == head.id);
  assign head_go   = head.committed | (head_hit & ~commit_kill_i);
  assign head_kill = head.killed | (head_hit & commit_kill_i);

  assign pop_in = ((head.op == OP_LDCNT) ? rdata_q : head.rs0) & head.rs1;

  bit_popcount #(.XLEN(XLEN)) u_popcount (
    .data_i  (pop_in),
    .count_o (pop_cnt)
  );

  always_comb begin
    q_d            = q_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    state_d        = state_q;
    rdata_d        = rdata_q;
    data_d         = data_q;
    deq            = 1'b0;
    mem_valid_o    = 1'b0;
    result_valid_o = 1'b0;

    for (int i = 0; i < DEPTH; i++) begin
      if (commit_valid_i && ent_valid[i] && (q_q[i].id == commit_id_i)) begin
        if (commit_kill_i) q_d[i].killed    = 1'b1;
        else               q_d[i].committed = 1'b1;
      end
    end

    if (enq) begin
      q_d[tail_q] = '{id:        issue_id_i,
                      rd:        issue_instr_i[11:7],
                      op:        issue_op,
                      rs0:       issue_rs0_i,
                      rs1:       issue_rs1_i,
                      committed: commit_valid_i && (commit_id_i == issue_id_i) && !commit_kill_i,
                      killed:    commit_valid_i && (commit_id_i == issue_id_i) && commit_kill_i};
      tail_d = tail_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          if (head_kill)    deq     = 1'b1;
          else if (head_go) state_d = (head.op == OP_LDCNT) ? S_MEMREQ : S_EXEC;
        end
      end
      S_MEMREQ: begin
        mem_valid_o = 1'b1;
        if (mem_ready_i) state_d = S_MEMWAIT;
      end
      S_MEMWAIT: begin
        if (mem_result_valid_i) begin
          rdata_d = mem_rdata_i;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        data_d  = {{(XLEN-NW){1'b0}}, pop_cnt};
        state_d = S_RESULT;
      end
      S_RESULT: begin
        result_valid_o = 1'b1;
        if (result_ready_i) begin
          deq     = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (deq) head_d = head_q + 1'b1;
    case ({enq, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= S_IDLE;
      rdata_q <= '0;
      data_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      state_q <= state_d;
      rdata_q <= rdata_d;
      data_q  <= data_d;
    end
  end

  // Payload storage needs no reset: slots are only read while live.
  always_ff @(posedge clk_i) begin
    q_q <= q_d;
  end

  assign mem_id_o      = mem_valid_o ? head.id : '0;
  assign mem_addr_o    = mem_valid_o ? head.rs0[31:0] : '0;
  assign mem_we_o      = 1'b0;
  assign mem_be_o      = '1;
  assign mem_mode_o    = 2'b00;
  assign mem_spec_o    = 1'b0;
  assign result_id_o   = result_valid_o ? head.id : '0;
  assign result_rd_o   = result_valid_o ? head.rd : '0;
  assign result_data_o = result_valid_o ? data_q : '0;
  assign result_we_o   = result_valid_o;

  assign unused_ok = ^issue_instr_i[31:12];

endmodule

// File: tb/tb_xif_bitcoproc.sv
// Directed plus randomized checks of xif_bitcoproc against a queue-level model.
module tb_xif_bitcoproc;

  localparam logic [6:0] OP_CNTB  = 7'h2B;
  localparam logic [6:0] OP_LDCNT = 7'h5B;
  localparam logic [6:0] OP_BAD   = 7'h0B;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        issue_valid_i = 1'b0;
  logic        issue_ready_o;
  logic [31:0] issue_instr_i = 32'h0;
  logic [3:0]  issue_id_i = 4'h0;
  logic [31:0] issue_rs0_i = 32'h0;
  logic [31:0] issue_rs1_i = 32'h0;
  logic        issue_accept_o, issue_writeback_o, issue_loadstore_o;
  logic        commit_valid_i = 1'b0;
  logic [3:0]  commit_id_i = 4'h0;
  logic        commit_kill_i = 1'b0;
  logic        mem_valid_o;
  logic        mem_ready_i = 1'b0;
  logic [3:0]  mem_id_o;
  logic [31:0] mem_addr_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [1:0]  mem_mode_o;
  logic        mem_spec_o;
  logic        mem_result_valid_i = 1'b0;
  logic [31:0] mem_rdata_i = 32'h0;
  logic        result_valid_o;
  logic        result_ready_i = 1'b0;
  logic [3:0]  result_id_o;
  logic [4:0]  result_rd_o;
  logic [31:0] result_data_o;
  logic        result_we_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  xif_bitcoproc #(.XLEN(32), .ID_WIDTH(4), .DEPTH(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_instr_i(issue_instr_i), .issue_id_i(issue_id_i),
    .issue_rs0_i(issue_rs0_i), .issue_rs1_i(issue_rs1_i),
    .issue_accept_o(issue_accept_o), .issue_writeback_o(issue_writeback_o),
    .issue_loadstore_o(issue_loadstore_o),
    .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_id_o(mem_id_o),
    .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_mode_o(mem_mode_o), .mem_spec_o(mem_spec_o),
    .mem_result_valid_i(mem_result_valid_i), .mem_rdata_i(mem_rdata_i),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .result_id_o(result_id_o), .result_rd_o(result_rd_o),
    .result_data_o(result_data_o), .result_we_o(result_we_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [31:0] popc(input logic [31:0] v);
    return 32'($countones(v));
  endfunction

  task automatic issue(input logic [6:0] op, input logic [3:0] id, input logic [4:0] rd,
                       input logic [31:0] rs0, input logic [31:0] rs1,
                       input logic cmt, input logic kill);
    int n;
    logic known;
    known          = (op == OP_CNTB) || (op == OP_LDCNT);
    issue_valid_i  = 1'b1;
    issue_instr_i  = {20'($urandom()), rd, op};
    issue_id_i     = id;
    issue_rs0_i    = rs0;
    issue_rs1_i    = rs1;
    commit_valid_i = cmt;
    commit_id_i    = id;
    commit_kill_i  = kill;
    n = 0;
    while (!issue_ready_o && n < 50) begin
      cyc();
      n++;
    end
    #1;
    chk("issue_ready_wait", 64'(n < 50), 64'd1);
    chk("issue_accept", 64'(issue_accept_o), 64'(known));
    chk("issue_writeback", 64'(issue_writeback_o), 64'(known));
    chk("issue_loadstore", 64'(issue_loadstore_o), 64'(op == OP_LDCNT));
    @(posedge clk_i);
    #1;
    issue_valid_i  = 1'b0;
    commit_valid_i = 1'b0;
    commit_kill_i  = 1'b0;
  endtask

  task automatic commit(input logic [3:0] id, input logic kill);
    commit_valid_i = 1'b1;
    commit_id_i    = id;
    commit_kill_i  = kill;
    cyc();
    commit_valid_i = 1'b0;
    commit_kill_i  = 1'b0;
  endtask

  task automatic mem_service(input logic [3:0] id, input logic [31:0] addr,
                             input int rdy_dly, input int rsp_dly, input logic [31:0] data);
    int n;
    n = 0;
    while (!mem_valid_o && n < 100) begin
      cyc();
      n++;
    end
    chk("mem_req_wait", 64'(n < 100), 64'd1);
    chk("mem_id", 64'(mem_id_o), 64'(id));
    chk("mem_addr", 64'(mem_addr_o), 64'(addr));
    for (int k = 0; k < rdy_dly; k++) begin
      cyc();
      chk("mem_valid_held", 64'(mem_valid_o), 64'd1);
      chk("mem_addr_held", 64'(mem_addr_o), 64'(addr));
    end
    mem_ready_i = 1'b1;
    cyc();
    mem_ready_i = 1'b0;
    repeat (rsp_dly) cyc();
    mem_result_valid_i = 1'b1;
    mem_rdata_i        = data;
    cyc();
    mem_result_valid_i = 1'b0;
    $display("mem id=%0d addr=0x%08h rdata=0x%08h", id, addr, data);
  endtask

  task automatic expect_result(input logic [3:0] id, input logic [4:0] rd, input logic [31:0] data);
    int n;
    logic saw_mem;
    n = 0;
    saw_mem = 1'b0;
    while (!result_valid_o && n < 100) begin
      saw_mem |= mem_valid_o;
      cyc();
      n++;
    end
    chk("result_wait", 64'(n < 100), 64'd1);
    chk("no_mem_while_waiting", 64'(saw_mem), 64'd0);
    repeat ($urandom_range(0, 2)) begin
      cyc();
      chk("result_valid_held", 64'(result_valid_o), 64'd1);
    end
    chk("result_id", 64'(result_id_o), 64'(id));
    chk("result_rd", 64'(result_rd_o), 64'(rd));
    chk("result_data", 64'(result_data_o), 64'(data));
    chk("result_we", 64'(result_we_o), 64'd1);
    $display("result id=%0d rd=%0d data=%0d", result_id_o, result_rd_o, result_data_o);
    result_ready_i = 1'b1;
    cyc();
    result_ready_i = 1'b0;
  endtask

  task automatic watch_idle(input int cycles, input string tag);
    logic saw;
    saw = 1'b0;
    for (int k = 0; k < cycles; k++) begin
      saw |= mem_valid_o | result_valid_o;
      cyc();
    end
    chk(tag, 64'(saw), 64'd0);
  endtask

  task automatic reset_outputs(input string tag);
    chk({tag, "_ready"}, 64'(issue_ready_o), 64'd1);
    chk({tag, "_accept"}, 64'(issue_accept_o), 64'd0);
    chk({tag, "_memvalid"}, 64'(mem_valid_o), 64'd0);
    chk({tag, "_be"}, 64'(mem_be_o), 64'hF);
    chk({tag, "_resvalid"}, 64'(result_valid_o), 64'd0);
    chk({tag, "_resdata"}, 64'(result_data_o), 64'd0);
  endtask

  // Reference model for one randomized batch.
  logic [6:0]  m_op   [4];
  logic [3:0]  m_id   [4];
  logic [4:0]  m_rd   [4];
  logic [31:0] m_rs0  [4];
  logic [31:0] m_rs1  [4];
  logic        m_kill [4];
  logic        m_cmt  [4];

  initial begin
    logic [31:0] d;
    int nb;

    // Reset with a valid opcode on the bus: responses must stay low.
    issue_instr_i = {20'h0, 5'd1, OP_CNTB};
    repeat (2) cyc();
    reset_outputs("reset");
    rst_ni = 1'b1;
    cyc();

    // CNTB: popcount(0xFFFF00FF & 0x0F0F0F0F) = 12, visible two cycles after commit.
    issue(OP_CNTB, 4'd1, 5'd5, 32'hFFFF_00FF, 32'h0F0F_0F0F, 1'b0, 1'b0);
    commit(4'd1, 1'b0);
    chk("cntb_not_yet", 64'(result_valid_o), 64'd0);
    cyc();
    chk("cntb_latency", 64'(result_valid_o), 64'd1);
    expect_result(4'd1, 5'd5, 32'd12);

    // LDCNT with memory returning 0x8000_0001.
    issue(OP_LDCNT, 4'd2, 5'd7, 32'h0000_0100, 32'hFFFF_FFFF, 1'b0, 1'b0);
    commit(4'd2, 1'b0);
    mem_service(4'd2, 32'h100, 3, 2, 32'h8000_0001);
    expect_result(4'd2, 5'd7, 32'd2);

    // Fill the queue, then release one entry with result_ready held.
    for (int i = 0; i < 4; i++) begin
      m_rs0[i] = 32'hFF << (i * 4);
      issue(OP_CNTB, 4'(4 + i), 5'(10 + i), m_rs0[i], 32'hFFFF_FFFF, 1'b0, 1'b0);
    end
    chk("full_ready_low", 64'(issue_ready_o), 64'd0);
    result_ready_i = 1'b1;
    commit(4'd4, 1'b0);
    chk("full_after_commit", 64'(issue_ready_o), 64'd0);
    cyc();
    chk("full_result_valid", 64'(result_valid_o), 64'd1);
    chk("full_result_data", 64'(result_data_o), 64'(popc(m_rs0[0])));
    cyc();
    result_ready_i = 1'b0;
    chk("ready_after_deq", 64'(issue_ready_o), 64'd1);
    for (int i = 1; i < 4; i++) begin
      commit(4'(4 + i), 1'b0);
      expect_result(4'(4 + i), 5'(10 + i), popc(m_rs0[i]));
    end

    // Killed LDCNT leaves no trace; the next CNTB still completes.
    issue(OP_LDCNT, 4'd3, 5'd9, 32'h200, 32'hFFFF_FFFF, 1'b0, 1'b0);
    commit(4'd3, 1'b1);
    watch_idle(8, "kill_silent");
    chk("kill_queue_empty", 64'(issue_ready_o), 64'd1);
    issue(OP_CNTB, 4'd8, 5'd3, 32'hF0F0_F0F0, 32'hFFFF_0000, 1'b0, 1'b0);
    commit(4'd8, 1'b0);
    expect_result(4'd8, 5'd3, 32'd8);

    // Unknown opcode takes no slot: three more fit before the queue is full.
    issue(OP_BAD, 4'd9, 5'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    commit(4'd9, 1'b0);
    watch_idle(4, "bad_no_result");
    for (int i = 0; i < 3; i++) issue(OP_CNTB, 4'(10 + i), 5'(i), 32'h1 << i, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk("bad_not_counted", 64'(issue_ready_o), 64'd1);
    issue(OP_CNTB, 4'd13, 5'd3, 32'h7, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk("bad_then_full", 64'(issue_ready_o), 64'd0);
    for (int i = 0; i < 4; i++) begin
      commit(4'(10 + i), 1'b0);
      expect_result(4'(10 + i), 5'(i), (i == 3) ? 32'd3 : 32'd1);
    end

    // Reset while waiting for memory; the late response must be ignored.
    issue(OP_LDCNT, 4'd14, 5'd2, 32'h300, 32'hFFFF_FFFF, 1'b0, 1'b0);
    commit(4'd14, 1'b0);
    chk("memwait_req", 64'(mem_valid_o), 64'd1);
    mem_ready_i = 1'b1;
    cyc();
    mem_ready_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    reset_outputs("midreset");
    cyc();
    rst_ni = 1'b1;
    cyc();
    mem_result_valid_i = 1'b1;
    mem_rdata_i        = 32'hFFFF_FFFF;
    cyc();
    mem_result_valid_i = 1'b0;
    watch_idle(8, "late_rsp_ignored");
    chk("after_reset_ready", 64'(issue_ready_o), 64'd1);

    // Randomized batches, in-order service against the model.
    for (int r = 0; r < 25; r++) begin
      nb = $urandom_range(1, 4);
      for (int i = 0; i < nb; i++) begin
        m_op[i]   = ($urandom_range(0, 1) == 0) ? OP_CNTB : OP_LDCNT;
        m_id[i]   = 4'(r * 4 + i);
        m_rd[i]   = 5'($urandom());
        m_rs0[i]  = $urandom();
        m_rs1[i]  = $urandom();
        m_kill[i] = ($urandom_range(0, 3) == 0);
        m_cmt[i]  = ($urandom_range(0, 2) == 0);
        issue(m_op[i], m_id[i], m_rd[i], m_rs0[i], m_rs1[i], m_cmt[i], m_kill[i]);
      end
      for (int i = 0; i < nb; i++) begin
        if (!m_cmt[i]) commit(m_id[i], m_kill[i]);
      end
      for (int i = 0; i < nb; i++) begin
        if (m_kill[i]) continue;
        if (m_op[i] == OP_LDCNT) begin
          d = $urandom();
          mem_service(m_id[i], m_rs0[i], $urandom_range(0, 3), $urandom_range(0, 3), d);
          expect_result(m_id[i], m_rd[i], popc(d & m_rs1[i]));
        end else begin
          expect_result(m_id[i], m_rd[i], popc(m_rs0[i] & m_rs1[i]));
        end
      end
      watch_idle(6, "batch_drained");
      chk("batch_queue_empty", 64'(issue_ready_o), 64'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
